// File: rtl/ibuf_frame_sched.sv
// Frame sequencer in front of the input buffer: forwards upstream words, marks
// frame/line boundaries and paces one sram2reg request per output row pair.
`timescale 1ns/1ps
module ibuf_frame_sched #(
  parameter int unsigned dw = 128,
  parameter int unsigned aw = 10
) (
  input  logic          SYS_CLK,
  input  logic          SYS_NRST,
  input  logic          cfg_start,
  input  logic [3:0]    cfg_mode,
  input  logic          cfg_padding,
  input  logic [5:0]    cfg_pic_size,
  input  logic [aw-1:0] cfg_addr_start,
  input  logic [7:0]    cfg_beats_per_row,
  input  logic [dw-1:0] src_data,
  input  logic          src_valid,
  output logic          src_ready,
  output logic [dw-1:0] ib_wr_data,
  output logic          ib_wr_valid,
  input  logic          ib_wr_ready,
  output logic          ib_wr_sop,
  output logic          ib_wr_hsync,
  output logic [aw-1:0] ib_wr_addr_start,
  output logic          sram2reg_valid,
  input  logic          sram2reg_ready,
  input  logic          opu_valid,
  input  logic          opu_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned PIC_W  = 6;
  localparam int unsigned LINE_W = 7;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned CMP_W  = 9;

  typedef enum logic [2:0] {S_IDLE, S_SOP, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                fc_q, fc_d;
  logic                padding_q, padding_d;
  logic [PIC_W-1:0]    pic_q, pic_d;
  logic [aw-1:0]       addr_q, addr_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [PIC_W-1:0]    word_cnt_q, word_cnt_d;
  logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0]   trig_cnt_q, trig_cnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                sop_q, sop_d;
  logic                hsync_q, hsync_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                start_c;
  logic [LINE_W-1:0]   t_c;
  logic [LINE_W-1:0]   lines_c;
  logic [CMP_W-1:0]    ahead_c;
  logic [CMP_W-1:0]    need_c;
  logic                load_en_c;
  logic                wr_beat_c;
  logic                line_end_c;
  logic                req_hs_c;
  logic                opu_hs_c;
  logic                req_cond_c;
  logic                mode_unused_c;

  assign mode_unused_c = ^cfg_mode[2:0];

  // Frame geometry and load/request qualifiers
  always_comb begin
    start_c    = (state_q == S_IDLE) && cfg_start;
    t_c        = fc_q ? LINE_W'(1) : LINE_W'(pic_q >> 1) + LINE_W'(padding_q);
    lines_c    = LINE_W'(pic_q);
    ahead_c    = CMP_W'({trig_cnt_q, 1'b0}) + CMP_W'(2);
    need_c     = (ahead_c < CMP_W'(lines_c)) ? ahead_c : CMP_W'(lines_c);
    load_en_c  = (state_q == S_RUN) && (line_cnt_q < lines_c) &&
                 (CMP_W'(line_cnt_q) < ahead_c);
    wr_beat_c  = src_valid && ib_wr_ready && load_en_c;
    line_end_c = wr_beat_c && (word_cnt_q == PIC_W'(pic_q - PIC_W'(1)));
    req_hs_c   = req_q && sram2reg_ready;
    opu_hs_c   = opu_valid && opu_ready;
    req_cond_c = (state_q == S_RUN) && (trig_cnt_q < t_c) &&
                 (CMP_W'(line_cnt_q) >= need_c) &&
                 ((trig_cnt_q == '0) || (beat_cnt_q == beats_q));
  end

  assign ib_wr_data  = src_data;
  assign ib_wr_valid = src_valid && load_en_c;
  assign src_ready   = ib_wr_ready && load_en_c;

  // State register
  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_start) state_d = S_SOP;
      S_SOP:   state_d = S_RUN;
      S_RUN:   if (trig_cnt_q == t_c) state_d = S_DRAIN;
      S_DRAIN: if (beat_cnt_q == beats_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, aligned with the state they describe
  always_comb begin
    sop_d   = (state_d == S_SOP);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    hsync_d = line_end_c;
    req_d   = req_q ? !sram2reg_ready : req_cond_c;
  end

  // Config capture and frame counters
  always_comb begin
    fc_d       = fc_q;
    padding_d  = padding_q;
    pic_d      = pic_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    word_cnt_d = word_cnt_q;
    line_cnt_d = line_cnt_q;
    trig_cnt_d = trig_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (start_c) begin
      fc_d       = cfg_mode[3];
      padding_d  = cfg_padding;
      pic_d      = cfg_pic_size;
      addr_d     = cfg_addr_start;
      beats_d    = cfg_beats_per_row;
      word_cnt_d = '0;
      line_cnt_d = '0;
      trig_cnt_d = '0;
      beat_cnt_d = '0;
    end else begin
      if (line_end_c) begin
        word_cnt_d = '0;
        line_cnt_d = line_cnt_q + LINE_W'(1);
      end else if (wr_beat_c) begin
        word_cnt_d = word_cnt_q + PIC_W'(1);
      end
      // An OPU beat coinciding with the request handshake belongs to the new row
      if (req_hs_c) begin
        trig_cnt_d = trig_cnt_q + LINE_W'(1);
        beat_cnt_d = (opu_hs_c && (beats_q != '0)) ? BEAT_W'(1) : '0;
      end else if (opu_hs_c && (state_q != S_IDLE) && (beat_cnt_q < beats_q)) begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      fc_q       <= 1'b0;
      padding_q  <= 1'b0;
      pic_q      <= '0;
      addr_q     <= '0;
      beats_q    <= '0;
      word_cnt_q <= '0;
      line_cnt_q <= '0;
      trig_cnt_q <= '0;
      beat_cnt_q <= '0;
      sop_q      <= 1'b0;
      hsync_q    <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fc_q       <= fc_d;
      padding_q  <= padding_d;
      pic_q      <= pic_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      word_cnt_q <= word_cnt_d;
      line_cnt_q <= line_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      sop_q      <= sop_d;
      hsync_q    <= hsync_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ib_wr_sop        = sop_q;
  assign ib_wr_hsync      = hsync_q;
  assign ib_wr_addr_start = addr_q;
  assign sram2reg_valid   = req_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_ibuf_frame_sched.sv
// Directed bench for ibuf_frame_sched: frame sequencing, request pacing and reset.
`timescale 1ns/1ps
module tb_ibuf_frame_sched;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 10;

  logic          SYS_CLK = 1'b0;
  logic          SYS_NRST;
  logic          cfg_start;
  logic [3:0]    cfg_mode;
  logic          cfg_padding;
  logic [5:0]    cfg_pic_size;
  logic [AW-1:0] cfg_addr_start;
  logic [7:0]    cfg_beats_per_row;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] ib_wr_data;
  logic          ib_wr_valid;
  logic          ib_wr_ready;
  logic          ib_wr_sop;
  logic          ib_wr_hsync;
  logic [AW-1:0] ib_wr_addr_start;
  logic          sram2reg_valid;
  logic          sram2reg_ready;
  logic          opu_valid;
  logic          opu_ready;
  logic          busy;
  logic          done;

  ibuf_frame_sched #(.dw(DW), .aw(AW)) dut (
    .SYS_CLK(SYS_CLK), .SYS_NRST(SYS_NRST),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_padding(cfg_padding),
    .cfg_pic_size(cfg_pic_size), .cfg_addr_start(cfg_addr_start),
    .cfg_beats_per_row(cfg_beats_per_row),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .ib_wr_data(ib_wr_data), .ib_wr_valid(ib_wr_valid), .ib_wr_ready(ib_wr_ready),
    .ib_wr_sop(ib_wr_sop), .ib_wr_hsync(ib_wr_hsync),
    .ib_wr_addr_start(ib_wr_addr_start),
    .sram2reg_valid(sram2reg_valid), .sram2reg_ready(sram2reg_ready),
    .opu_valid(opu_valid), .opu_ready(opu_ready),
    .busy(busy), .done(done)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_checks = 0;
  int n_errors = 0;

  int wr_cnt = 0, hs_cnt = 0, sop_cnt = 0, req_cnt = 0, opu_cnt = 0;
  int opu_target = 0, opu_issued = 0, cyc = 0;
  int hs2_cyc = 0, req1_cyc = 0;
  int wr_base = 0, hs_base = 0, sop_base = 0, req_base = 0, opu_base = 0;
  logic rnd = 1'b0;
  logic req_prev = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned n);
    return {4{n}};
  endfunction

  // Upstream source: next unconsumed word, optionally bursty with a toggling buffer ready
  initial forever begin
    @(posedge SYS_CLK); #1;
    src_data    = pat(wr_cnt);
    src_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    ib_wr_ready = rnd ? ~ib_wr_ready : 1'b1;
  end

  // OPU model: issues cfg_beats_per_row handshakes after each accepted request
  initial forever begin
    @(posedge SYS_CLK); #1;
    if (opu_issued < opu_target) begin
      opu_valid = 1'b1;
      opu_ready = 1'b1;
      opu_issued++;
    end else begin
      opu_valid = 1'b0;
      opu_ready = 1'b0;
    end
  end

  // Event monitor, sampled on the falling edge
  initial forever begin
    @(negedge SYS_CLK);
    cyc++;
    if (ib_wr_valid && ib_wr_ready) begin
      check("wr_data_order", 128'(ib_wr_data), 128'(pat(wr_cnt)));
      wr_cnt++;
    end
    if (ib_wr_hsync) begin
      if (hs_cnt - hs_base == 1) hs2_cyc = cyc;
      hs_cnt++;
    end
    if (ib_wr_sop) sop_cnt++;
    if (sram2reg_valid && !req_prev && req_cnt == req_base) req1_cyc = cyc;
    req_prev = sram2reg_valid;
    if (sram2reg_valid && sram2reg_ready) begin
      req_cnt++;
      opu_target += int'(cfg_beats_per_row);
    end
    if (opu_valid && opu_ready) opu_cnt++;
  end

  task automatic start_frame(input logic [5:0] pic, input logic pad, input logic [3:0] mode,
                             input logic [7:0] beats, input logic [AW-1:0] addr);
    wr_base  = wr_cnt;
    hs_base  = hs_cnt;
    sop_base = sop_cnt;
    req_base = req_cnt;
    opu_base = opu_cnt;
    cfg_pic_size      = pic;
    cfg_padding       = pad;
    cfg_mode          = mode;
    cfg_beats_per_row = beats;
    cfg_addr_start    = addr;
    cfg_start         = 1'b1;
    @(posedge SYS_CLK); #1;
    cfg_start = 1'b0;
    check("sop_after_start", 128'(ib_wr_sop), 128'(1));
    check("busy_after_start", 128'(busy), 128'(1));
    check("addr_latched", 128'(ib_wr_addr_start), 128'(addr));
    @(posedge SYS_CLK); #1;
    check("sop_one_cycle", 128'(ib_wr_sop), 128'(0));
  endtask

  task automatic finish_frame(input int exp_req, input int exp_opu, input int exp_wr,
                              input int exp_hs, input logic [AW-1:0] exp_addr);
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge SYS_CLK); #1;
    end
    check("done_seen", 128'(done), 128'(1));
    check("busy_with_done", 128'(busy), 128'(1));
    check("req_count", 128'(req_cnt - req_base), 128'(exp_req));
    check("opu_beats_at_done", 128'(opu_cnt - opu_base), 128'(exp_opu));
    check("sop_count", 128'(sop_cnt - sop_base), 128'(1));
    check("addr_held", 128'(ib_wr_addr_start), 128'(exp_addr));
    if (exp_wr >= 0) check("write_beats", 128'(wr_cnt - wr_base), 128'(exp_wr));
    if (exp_hs >= 0) check("hsync_count", 128'(hs_cnt - hs_base), 128'(exp_hs));
    @(posedge SYS_CLK); #1;
    check("done_one_cycle", 128'(done), 128'(0));
    check("busy_drops", 128'(busy), 128'(0));
  endtask

  task automatic check_all_low(input string tag);
    check(tag, 128'({busy, done, ib_wr_sop, ib_wr_hsync, sram2reg_valid, ib_wr_valid,
                     src_ready, ib_wr_addr_start}), 128'(0));
  endtask

  initial begin
    int stable;
    SYS_NRST          = 1'b0;
    cfg_start         = 1'b0;
    cfg_mode          = '0;
    cfg_padding       = 1'b0;
    cfg_pic_size      = '0;
    cfg_addr_start    = '0;
    cfg_beats_per_row = '0;
    sram2reg_ready    = 1'b1;
    repeat (3) @(posedge SYS_CLK);
    #1;
    check_all_low("reset_outputs");
    SYS_NRST = 1'b1;
    @(posedge SYS_CLK); #1;

    // Baseline 4x4 frame, two requests of three beats
    start_frame(6'd4, 1'b0, 4'b0000, 8'd3, 10'h055);
    finish_frame(2, 6, 16, 4, 10'h055);
    check("req_after_line2_latency", 128'(req1_cyc - hs2_cyc), 128'(1));

    // Padding adds a third request; a start pulse while busy is ignored
    start_frame(6'd4, 1'b1, 4'b0000, 8'd3, 10'h155);
    repeat (5) @(posedge SYS_CLK);
    #1;
    cfg_addr_start = 10'h3aa;
    cfg_start = 1'b1;
    @(posedge SYS_CLK); #1;
    cfg_start = 1'b0;
    finish_frame(3, 9, 16, 4, 10'h155);

    // Fully-connected: one request, loading stalls at two lines, request held under backpressure
    sram2reg_ready = 1'b0;
    start_frame(6'd8, 1'b0, 4'b1000, 8'd8, 10'h200);
    for (int i = 0; i < 100 && !sram2reg_valid; i++) begin
      @(posedge SYS_CLK); #1;
    end
    check("fc_req_raised", 128'(sram2reg_valid), 128'(1));
    check("fc_two_lines_loaded", 128'(wr_cnt - wr_base), 128'(16));
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge SYS_CLK); #1;
      if (sram2reg_valid) stable++;
    end
    check("req_held_10_cycles", 128'(stable), 128'(10));
    check("no_handshake_while_stalled", 128'(req_cnt - req_base), 128'(0));
    check("load_stalled", 128'({ib_wr_valid, src_ready}), 128'(0));
    check("still_two_lines", 128'(wr_cnt - wr_base), 128'(16));
    sram2reg_ready = 1'b1;
    finish_frame(1, 8, -1, -1, 10'h200);

    // Bursty source and toggling buffer ready give the same frame totals
    rnd = 1'b1;
    start_frame(6'd4, 1'b0, 4'b0000, 8'd3, 10'h011);
    finish_frame(2, 6, 16, 4, 10'h011);
    rnd = 1'b0;
    @(posedge SYS_CLK); #1;

    // Reset mid-frame, then a clean restart
    start_frame(6'd4, 1'b0, 4'b0000, 8'd3, 10'h0f0);
    repeat (4) @(posedge SYS_CLK);
    #1;
    check("busy_before_reset", 128'(busy), 128'(1));
    SYS_NRST = 1'b0;
    #1;
    check_all_low("reset_mid_run");
    @(posedge SYS_CLK); #1;
    SYS_NRST = 1'b1;
    @(posedge SYS_CLK); #1;
    start_frame(6'd4, 1'b0, 4'b0000, 8'd3, 10'h0f1);
    finish_frame(2, 6, 16, 4, 10'h0f1);

    // Zero beats per row: requests depend only on lines
    start_frame(6'd4, 1'b0, 4'b0000, 8'd0, 10'h001);
    finish_frame(2, 0, 16, 4, 10'h001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
